// File: rtl/xalu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_sched
//  Description : Execute-stage multiply/divide sequencer. Owns HI/LO, feeds a
//                fixed-latency pipelined multiplier and a start/done iterative
//                divider, and raises busy while an operation is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module xalu_sched #(
    parameter int MUL_LAT = 3
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic [63:0] mul_prod,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic        div_abort
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MUL_WAIT  = 2'd1,
        S_DIV_START = 2'd2,
        S_DIV_WAIT  = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MADD  = 4'd5;
    localparam logic [3:0] c_OP_MADDU = 4'd6;
    localparam logic [3:0] c_OP_MSUB  = 4'd7;
    localparam logic [3:0] c_OP_MSUBU = 4'd8;
    localparam logic [3:0] c_OP_MUL   = 4'd9;
    localparam logic [3:0] c_OP_MTHI  = 4'd10;
    localparam logic [3:0] c_OP_MTLO  = 4'd11;
    localparam logic [3:0] c_MUL_LAT  = 4'(MUL_LAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_result;
    logic        r_result_valid;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_signed;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic        r_div_signed;

    logic        w_accept;
    logic        w_op_mul;
    logic        w_op_div;
    logic        w_div_by_zero;
    logic        w_mul_done;
    logic        w_div_fin;
    logic [63:0] w_hilo;

    // Request decode and completion qualifiers; flush kills every update
    always_comb begin
        w_op_mul      = op inside {c_OP_MULT, c_OP_MULTU, c_OP_MADD, c_OP_MADDU,
                                   c_OP_MSUB, c_OP_MSUBU, c_OP_MUL};
        w_op_div      = (op == c_OP_DIV) || (op == c_OP_DIVU);
        w_div_by_zero = (src_b == 32'd0);
        w_accept      = op_valid && (r_state == S_IDLE) && !flush;
        w_mul_done    = (r_state == S_MUL_WAIT) && (r_cnt == 4'd1) && !flush;
        w_div_fin     = (r_state == S_DIV_WAIT) && div_done && !flush;
        w_hilo        = {r_hi, r_lo};
    end

    // Next-state logic and the divider control strobes
    always_comb begin
        w_state_nxt = r_state;
        div_start   = 1'b0;
        div_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op_mul) begin
                        w_state_nxt = S_MUL_WAIT;
                    end else if (w_op_div && !w_div_by_zero) begin
                        w_state_nxt = S_DIV_START;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV_START: begin
                div_start   = 1'b1;
                w_state_nxt = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if (div_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush wins over everything; only an active divide needs cancelling
        if (flush) begin
            w_state_nxt = S_IDLE;
            div_start   = 1'b0;
            div_abort   = (r_state == S_DIV_START) || (r_state == S_DIV_WAIT);
        end
    end

    // State register, registered busy, latency counter and latched opcode
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            r_op    <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_op <= op;
            end
            if (flush) begin
                r_cnt <= 4'd0;
            end else if (w_accept && w_op_mul) begin
                r_cnt <= c_MUL_LAT;
            end else if (r_state == S_MUL_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Operand registers: loaded on accept and held until the next accept
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_mul_a      <= 32'd0;
            r_mul_b      <= 32'd0;
            r_mul_signed <= 1'b0;
            r_div_a      <= 32'd0;
            r_div_b      <= 32'd0;
            r_div_signed <= 1'b0;
        end else begin
            if (w_accept && w_op_mul) begin
                r_mul_a      <= src_a;
                r_mul_b      <= src_b;
                r_mul_signed <= op inside {c_OP_MULT, c_OP_MADD, c_OP_MSUB, c_OP_MUL};
            end
            if (w_accept && w_op_div && !w_div_by_zero) begin
                r_div_a      <= src_a;
                r_div_b      <= src_b;
                r_div_signed <= (op == c_OP_DIV);
            end
        end
    end

    // Architectural HI/LO: moves, multiply/accumulate writeback, divide writeback
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_accept && (op == c_OP_MTHI)) begin
            r_hi <= src_a;
        end else if (w_accept && (op == c_OP_MTLO)) begin
            r_lo <= src_a;
        end else if (w_mul_done) begin
            case (r_op)
                c_OP_MULT, c_OP_MULTU: {r_hi, r_lo} <= mul_prod;
                c_OP_MADD, c_OP_MADDU: {r_hi, r_lo} <= w_hilo + mul_prod;
                c_OP_MSUB, c_OP_MSUBU: {r_hi, r_lo} <= w_hilo - mul_prod;
                default:               {r_hi, r_lo} <= w_hilo;
            endcase
        end else if (w_div_fin) begin
            r_lo <= div_quot;
            r_hi <= div_rem;
        end
    end

    // MUL GPR result: low product word plus a one-cycle valid pulse
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_result       <= 32'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_mul_done && (r_op == c_OP_MUL);
            if (w_mul_done && (r_op == c_OP_MUL)) begin
                r_result <= mul_prod[31:0];
            end
        end
    end

    assign busy         = r_busy;
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign mul_signed   = r_mul_signed;
    assign div_a        = r_div_a;
    assign div_b        = r_div_b;
    assign div_signed   = r_div_signed;

endmodule
`default_nettype wire
